// File: rtl/axis_config_bus_writer.sv
// AXI-Stream to RPSPMC configuration bus initiator: one address word plus up to
// 16 data lanes per frame, then a timed address strobe. Optional macro CONFIG_BUS_WRITER_COUNT_EN adds write_count.

module config_lane #(
    parameter int VEC_W = 32
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             clr,
    input  logic             we,
    input  logic [VEC_W-1:0] d,
    output logic [VEC_W-1:0] q
);
    always_ff @(posedge aclk or posedge reset) begin
        if (reset)    q <= '0;
        else if (clr) q <= '0;
        else if (we)  q <= d;
    end
endmodule

module axis_config_bus_writer #(
    parameter logic [31:0] IDLE_ADDR     = 32'd0,
    parameter int          STROBE_CYCLES = 2,
    parameter int          NUM_LANES     = 16,
    parameter int          VEC_W         = 32
) (
    input  logic                       aclk,
    input  logic                       reset,
    input  logic [31:0]                S_AXIS_tdata,
    input  logic                       S_AXIS_tvalid,
    input  logic                       S_AXIS_tlast,
    output logic                       S_AXIS_tready,
    output logic [31:0]                config_addr,
    output logic [NUM_LANES*VEC_W-1:0] config_data,
`ifdef CONFIG_BUS_WRITER_COUNT_EN
    output logic [31:0]                write_count,
`endif
    output logic                       busy,
    output logic                       done,
    output logic                       overrun
);
    localparam int IDX_W = $clog2(NUM_LANES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_STROBE, S_GAP} state_t;

    typedef struct packed {
        logic [31:0] data;
        logic        last;
    } axis_beat_t;

    state_t                              state;
    axis_beat_t                          beat;
    logic [31:0]                         target;
    logic [IDX_W-1:0]                    idx;
    logic [7:0]                          strobe_cnt;
    logic                                accept;
    logic                                lane_clr;
    logic                                data_we;
    logic [NUM_LANES-1:0]                lane_we;
    logic [NUM_LANES-1:0][VEC_W-1:0]     lane_q;

    assign beat          = '{data: S_AXIS_tdata, last: S_AXIS_tlast};
    assign S_AXIS_tready = (state == S_IDLE) || (state == S_DATA);
    assign accept        = S_AXIS_tvalid && S_AXIS_tready;
    assign lane_clr      = accept && (state == S_IDLE);
    assign data_we       = accept && (state == S_DATA) && (idx < IDX_W'(NUM_LANES));

    // Lane registers only move while config_addr is idle, so decoders never
    // see a target address paired with changing data.
    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            assign lane_we[k] = data_we && (idx == IDX_W'(k));
            config_lane #(.VEC_W(VEC_W)) u_lane (
                .aclk  (aclk),
                .reset (reset),
                .clr   (lane_clr),
                .we    (lane_we[k]),
                .d     (beat.data[VEC_W-1:0]),
                .q     (lane_q[k])
            );
        end
    endgenerate

    assign config_data = lane_q;

    always_ff @(posedge aclk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            target      <= '0;
            idx         <= '0;
            strobe_cnt  <= '0;
            config_addr <= IDLE_ADDR;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        target  <= beat.data;
                        idx     <= '0;
                        overrun <= 1'b0;
                        if (beat.last) begin
                            state       <= S_STROBE;
                            config_addr <= beat.data;
                            busy        <= 1'b1;
                            strobe_cnt  <= 8'd1;
                        end else begin
                            state <= S_DATA;
                        end
                    end
                end
                S_DATA: begin
                    if (accept) begin
                        // idx parks at NUM_LANES; further words are dropped
                        if (idx == IDX_W'(NUM_LANES)) overrun <= 1'b1;
                        else                          idx     <= idx + 1'b1;
                        if (beat.last) begin
                            state       <= S_STROBE;
                            config_addr <= target;
                            busy        <= 1'b1;
                            strobe_cnt  <= 8'd1;
                        end
                    end
                end
                S_STROBE: begin
                    if (strobe_cnt == 8'(STROBE_CYCLES)) begin
                        state       <= S_GAP;
                        config_addr <= IDLE_ADDR;
                        done        <= 1'b1;
                    end else begin
                        strobe_cnt <= strobe_cnt + 8'd1;
                    end
                end
                S_GAP: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef CONFIG_BUS_WRITER_COUNT_EN
    always_ff @(posedge aclk or posedge reset) begin
        if (reset)               write_count <= '0;
        else if (state == S_GAP) write_count <= write_count + 32'd1;
    end
`endif

endmodule

// File: tb/tb_axis_config_bus_writer.sv
// Directed bench for axis_config_bus_writer with STROBE_CYCLES=2.
module tb_axis_config_bus_writer;
    logic         aclk = 1'b0;
    logic         reset = 1'b1;
    logic [31:0]  S_AXIS_tdata = '0;
    logic         S_AXIS_tvalid = 1'b0;
    logic         S_AXIS_tlast = 1'b0;
    logic         S_AXIS_tready;
    logic [31:0]  config_addr;
    logic [511:0] config_data;
    logic         busy, done, overrun;
`ifdef CONFIG_BUS_WRITER_COUNT_EN
    logic [31:0]  write_count;
`endif

    int tests = 0;
    int failed = 0;

    always #5 aclk = ~aclk;

    axis_config_bus_writer #(.IDLE_ADDR(32'd0), .STROBE_CYCLES(2)) dut (
        .aclk          (aclk),
        .reset         (reset),
        .S_AXIS_tdata  (S_AXIS_tdata),
        .S_AXIS_tvalid (S_AXIS_tvalid),
        .S_AXIS_tlast  (S_AXIS_tlast),
        .S_AXIS_tready (S_AXIS_tready),
        .config_addr   (config_addr),
        .config_data   (config_data),
`ifdef CONFIG_BUS_WRITER_COUNT_EN
        .write_count   (write_count),
`endif
        .busy          (busy),
        .done          (done),
        .overrun       (overrun)
    );

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts and ends 1ns after a rising edge.
    task automatic send_word(input logic [31:0] d, input logic l, input int gap);
        logic acc;
        int   n;
        repeat (gap) begin @(posedge aclk); #1; end
        S_AXIS_tdata  = d;
        S_AXIS_tlast  = l;
        S_AXIS_tvalid = 1'b1;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            acc = S_AXIS_tready;
            @(posedge aclk); #1;
            n++;
        end
        S_AXIS_tvalid = 1'b0;
        S_AXIS_tlast  = 1'b0;
        if (!acc) check("accept_timeout", acc, 1'b1);
    endtask

    // Samples on falling edges; index 0 is the cycle after the call.
    task automatic observe(input logic [31:0] tgt, input int window,
                           output int addr_cnt, output int first_addr,
                           output int done_cnt, output int done_idx,
                           output int nrdy_cnt, output logic [511:0] snap);
        addr_cnt = 0; first_addr = -1; done_cnt = 0; done_idx = -1; nrdy_cnt = 0; snap = '0;
        for (int i = 0; i < window; i++) begin
            @(negedge aclk);
            if (config_addr == tgt) begin
                if (first_addr < 0) begin first_addr = i; snap = config_data; end
                addr_cnt++;
            end
            if (done) begin done_cnt++; if (done_idx < 0) done_idx = i; end
            if (!S_AXIS_tready) nrdy_cnt++;
        end
        @(posedge aclk); #1;
    endtask

    int           ac, fa, dc, di, nr, bad;
    logic [511:0] snap, exp;
    int           gaps[5] = '{0, 3, 7, 5, 1};

    initial begin
        repeat (3) @(posedge aclk);
        #1 reset = 1'b0;
        @(negedge aclk);
        check("rst_addr", config_addr, 32'd0);
        check("rst_data", config_data, 512'd0);
        check("rst_tready", S_AXIS_tready, 1'b1);
        check("rst_flags", {busy, done, overrun}, 3'b000);
`ifdef CONFIG_BUS_WRITER_COUNT_EN
        check("rst_count", write_count, 32'd0);
`endif
        @(posedge aclk); #1;

        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge aclk);
            if (config_addr != 32'd0 || busy || done || !S_AXIS_tready) bad++;
        end
        check("idle_100", bad, 0);
        @(posedge aclk); #1;

        // Basic write
        send_word(32'd999, 1'b0, 0);
        send_word(32'h7FFF_FFFF, 1'b0, 0);
        for (int i = 0; i < 3; i++) send_word(32'd0, 1'b0, 0);
        send_word(32'd0, 1'b1, 0);
        observe(32'd999, 8, ac, fa, dc, di, nr, snap);
        check("basic_addr_cycles", ac, 2);
        check("basic_addr_first", fa, 0);
        check("basic_data", snap, 512'h7FFF_FFFF);
        check("basic_done_cnt", dc, 1);
        check("basic_done_idx", di, 2);
        check("basic_nready", nr, 3);
        check("basic_data_hold", config_data, 512'h7FFF_FFFF);

        // Empty record clears data
        send_word(32'd999, 1'b1, 0);
        observe(32'd999, 8, ac, fa, dc, di, nr, snap);
        check("empty_addr_cycles", ac, 2);
        check("empty_data", snap, 512'd0);
        check("empty_done", dc, 1);

        // Overrun: 18 data words to 16 lanes
        send_word(32'd5, 1'b0, 0);
        for (int i = 1; i <= 18; i++) send_word(32'(i), (i == 18), 0);
        observe(32'd5, 8, ac, fa, dc, di, nr, snap);
        exp = '0;
        for (int k = 0; k < 16; k++) exp[32*k +: 32] = 32'(k + 1);
        check("ovr_addr_cycles", ac, 2);
        check("ovr_data", snap, exp);
        check("ovr_lane15", snap[511:480], 32'd16);
        check("ovr_flag", overrun, 1'b1);
        send_word(32'd7, 1'b0, 0);
        @(negedge aclk);
        check("ovr_cleared", overrun, 1'b0);
        check("ovr_data_cleared", config_data, 512'd0);
        @(posedge aclk); #1;
        send_word(32'hA, 1'b1, 0);
        observe(32'd7, 8, ac, fa, dc, di, nr, snap);
        check("after_ovr_data", snap, 512'hA);

        // Throttled frame matches unthrottled contents
        send_word(32'h33, 1'b0, gaps[0]);
        send_word(32'h11, 1'b0, gaps[1]);
        send_word(32'h22, 1'b0, gaps[2]);
        send_word(32'h33, 1'b0, gaps[3]);
        send_word(32'h44, 1'b1, gaps[4]);
        observe(32'h33, 8, ac, fa, dc, di, nr, snap);
        check("thr_data", snap, {32'h44, 32'h33, 32'h22, 32'h11});
        check("thr_addr_cycles", ac, 2);
        check("thr_addr_first", fa, 0);

        // Reset during STROBE
        send_word(32'h44, 1'b0, 0);
        send_word(32'hBEEF, 1'b1, 0);
        #2;
        check("strb_addr_before_rst", config_addr, 32'h44);
        check("strb_busy", busy, 1'b1);
        reset = 1'b1;
        #1;
        check("rst_strb_addr", config_addr, 32'd0);
        check("rst_strb_data", config_data, 512'd0);
        check("rst_strb_busy", busy, 1'b0);
        @(posedge aclk); #1 reset = 1'b0;
        observe(32'h44, 8, ac, fa, dc, di, nr, snap);
        check("rst_strb_no_addr", ac, 0);
        check("rst_strb_no_done", dc, 0);

        // Reset mid-frame drops the partial record
        send_word(32'h55, 1'b0, 0);
        send_word(32'h1, 1'b0, 0);
        reset = 1'b1;
        #2 reset = 1'b0;
        observe(32'h55, 8, ac, fa, dc, di, nr, snap);
        check("rst_frame_no_addr", ac, 0);
        check("rst_frame_no_done", dc, 0);
        check("rst_frame_data", config_data, 512'd0);

`ifdef CONFIG_BUS_WRITER_COUNT_EN
        for (int f = 0; f < 3; f++) begin
            send_word(32'(100 + f), 1'b0, 0);
            send_word(32'(f), 1'b1, 0);
            observe(32'(100 + f), 6, ac, fa, dc, di, nr, snap);
        end
        check("count_three", write_count, 32'd3);
        reset = 1'b1;
        #1;
        check("count_reset", write_count, 32'd0);
        @(posedge aclk); #1 reset = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/axis_config_bus_writer.md
# axis_config_bus_writer

Initiator side of the RPSPMC configuration bus: assembles a configuration record from a 32-bit AXI-Stream word stream and drives the shared `config_addr`/`config_data` bus that the filter, PLL and controller blocks decode. Each stream frame carries one target address followed by up to 16 data words. After the frame completes, the block presents the address for a programmable number of cycles, which loads and auto-resets the addressed block, then returns the bus to the idle address.

## Interface
- `IDLE_ADDR`, 0: value driven on `config_addr` when no write is in progress; no block may use this address.
- `STROBE_CYCLES`, 2: cycles the target address is held on `config_addr`; legal range is 1..255.
- `aclk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `S_AXIS_tdata`  in  32  word 0 of a frame is the target address; words 1..16 are config lanes 0..15.
- `S_AXIS_tvalid`  in  1  word valid.
- `S_AXIS_tlast`  in  1  marks the last word of the frame.
- `S_AXIS_tready`  out  1  word accepted when `tvalid & tready`.
- `config_addr`  out  32  configuration bus address.
- `config_data`  out  512  configuration bus data; lane k is bits [32k+31:32k].
- `busy`  out  1  high in STROBE and GAP.
- `done`  out  1  one-cycle pulse when the strobe ends.
- `overrun`  out  1  sticky; a frame had more than 16 data words.

## Operation
- The clock is `aclk`. Reset is asynchronous and active-high on `reset`.
- FSM states:
  - IDLE: `tready`=1. An accepted word is latched as the target address and all 512 data bits are cleared to 0.
    - `tlast`=0 on that word: go to DATA.
    - `tlast`=1 on that word (empty record): go to STROBE.
  - DATA: `tready`=1. Each accepted word is written to lane `idx`; `idx` starts at 0 and increments per word.
    - Word 17 and later are discarded and set `overrun`.
    - `tlast` accepted: go to STROBE.
  - STROBE: `tready`=0. `config_addr` = latched target; `config_data` is stable. Stays for `STROBE_CYCLES` cycles, then goes to GAP.
  - GAP: `tready`=0. `config_addr` = `IDLE_ADDR`; `done`=1 for this cycle. Next state is IDLE.
- `config_data` holds its last value after the strobe and changes only when a new address word is accepted.
- `overrun` is cleared when the next address word is accepted.
- Lanes not written in a frame read 0.
- Counters:
  - `idx` is 5 bits and saturates at 16; it does not wrap.
  - The strobe counter is 8 bits.
- `config_addr` must never show a target address while `config_data` is changing.

## Timing
- Reset values:
  - `config_addr` = `IDLE_ADDR`; `config_data` = 0.
  - `S_AXIS_tready` = 1; `busy` = `done` = `overrun` = 0.
  - FSM = IDLE.
- All outputs are registered. `tready` is decoded from the state register.
- Latency, with `tlast` accepted at cycle T and N = `STROBE_CYCLES`:
  - `config_addr` = target on cycles T+1 .. T+N.
  - `config_addr` = `IDLE_ADDR` and `done`=1 at T+N+1.
  - `tready`=1 again at T+N+2.
- `config_data` reflects the last lane written at T+1 at the latest.
- Back-to-back frames are separated by at least N+1 bus cycles.
- `tvalid` gaps inside a frame are allowed; the FSM waits in DATA indefinitely. There is no timeout.
- Asserting `reset` mid-frame or mid-strobe forces the reset values immediately. A partial frame is dropped and no strobe is issued.

## Configuration
- `CONFIG_BUS_WRITER_COUNT_EN`
  - Defined: adds output `write_count` (32 bits, reset 0). It increments in the GAP cycle of every completed write and wraps from 0xFFFFFFFF to 0.
  - Undefined: the port and counter are absent. All other behaviour is identical.

## Test plan
- Reset then idle:
  - After reset, `config_addr`=0, `config_data`=0 and `tready`=1.
  - With no stimulus, the bus stays idle for 100 cycles.
- Basic write:
  - Stimulus: frame {999, 0x7FFFFFFF, 0, 0, 0, 0} with the last word carrying `tlast`, N=2.
  - `config_addr`=999 for exactly 2 cycles.
  - `config_data[31:0]`=0x7FFFFFFF and bits [159:32]=0.
  - `done` pulses once; `tready` is low for 3 cycles.
- Empty record and clearing:
  - Stimulus: after the basic write, frame {999} with `tlast` on word 0.
  - `config_addr`=999 for 2 cycles with `config_data`=0.
- Overrun:
  - Stimulus: frame of address 5 plus 18 data words 1..18.
  - `overrun`=1; lane 15 = 16; words 17 and 18 are dropped.
  - The next frame's address word clears `overrun`.
- Throttled input and reset:
  - Stimulus: a 5-word frame with `tvalid` gaps of 0-7 cycles.
  - Stored data equals the unthrottled case.
  - A second frame is reset during STROBE: `config_addr` returns to 0 in the same cycle and `done` never pulses.
- Counter (macro defined):
  - Stimulus: three complete frames.
  - `write_count`=3. A reset returns it to 0.
